mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the multi-cycle CPU, directly upstream of the write-back stage.
- Consumes the EXE->MEM bus and drives the data-memory port (byte-lane write enables, byte-select on loads).
- Produces the 70-bit MEM->WB bus {wen, wdest[4:0], mem_result[31:0], pc[31:0]} plus MEM_over for the multi-cycle controller.
- Data memory is synchronous with a fixed, parameterised read latency.

Parameters:
LOAD_LATENCY, 1, data-memory read latency in cycles; legal 1..3.
CNT_W, 2, width of the load-wait counter; must hold LOAD_LATENCY.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
MEM_valid  input  1  MEM stage active (level from controller; held until MEM_over, then dropped)
EXE_MEM_bus_r  input  106  {mem_control[3:0], store_data[31:0], exe_result[31:0], wen, wdest[4:0], pc[31:0]}; mem_control = {inst_load, inst_store, ls_word, lb_sign}
dm_rdata  input  32  data-memory read data, valid LOAD_LATENCY cycles after address
dm_addr  output  32  word-aligned address {exe_result[31:2],2'b00}
dm_wen  output  4  byte write enables
dm_wdata  output  32  write data, lane-replicated
MEM_over  output  1  stage complete
MEM_WB_bus  output  70  {wen, wdest, mem_result, pc}
MEM_pc  output  32  pc for display
mem_addr_err  output  1  misaligned access flag (see Optional Feature)

Behaviour:
- Reset:
  - state=IDLE, wait counter=0, load_result_r=0.
  - All outputs are combinational from state and bus. With MEM_valid=0 after reset: dm_wen=0, MEM_over=0, mem_addr_err=0.
- States:
  - IDLE -> WAIT when MEM_valid & inst_load; load counter with LOAD_LATENCY-1.
  - IDLE -> DONE when MEM_valid & ~inst_load.
  - WAIT: counter decrements each cycle. When counter==0 and MEM_valid: capture the formatted dm_rdata into load_result_r and go to DONE.
  - DONE -> IDLE when MEM_valid==0. DONE stays while MEM_valid==1.
- MEM_over = (IDLE & MEM_valid & ~inst_load) | DONE.
  - Non-load instructions complete in the first valid cycle (0 added latency).
  - Loads complete LOAD_LATENCY+1 cycles after MEM_valid rises.
- Stores:
  - dm_wen is nonzero only in IDLE & MEM_valid & inst_store, so each write is exactly one cycle. Stores are never repeated while sitting in DONE.
  - sw: dm_wen=4'b1111, dm_wdata=store_data.
  - sb: dm_wen=4'b0001<<exe_result[1:0], dm_wdata={4{store_data[7:0]}}.
- Loads:
  - lw: result = dm_rdata.
  - lb/lbu: byte = dm_rdata[8*addr[1:0]+:8], sign-extended when lb_sign=1, else zero-extended.
  - Byte select uses exe_result[1:0] from the bus. The bus is held stable for the whole stage.
- mem_result = inst_load ? load_result_r : exe_result.
- MEM_WB_bus = {wen, wdest, mem_result, pc} whenever MEM_valid. MEM_pc = pc.
- Abort: MEM_valid falling in WAIT -> IDLE with no capture. load_result_r keeps its old value.
- Reset mid-operation: returns to IDLE in the next cycle regardless of state. An in-flight load is discarded. Any store enable is gone after the reset edge.
- inst_load and inst_store both set is illegal; load takes priority and no write is issued.

Optional Feature:
- Macro MEM_ALIGN_CHK_EN.
- Defined:
  - mem_addr_err=1 in IDLE & MEM_valid when (ls_word & exe_result[1:0]!=0) and (inst_load|inst_store).
  - The access is suppressed: dm_wen=0, no WAIT, go straight to DONE.
  - wen in MEM_WB_bus is forced to 0.
- Undefined:
  - mem_addr_err is tied 0.
  - Misaligned lw/sw use the word-aligned address silently.

Decomposition:
- Shared package holds:
  - bus widths EXE_MEM_W=106, MEM_WB_W=70;
  - mem_control bit indices;
  - state encoding IDLE/WAIT/DONE.
- One natural sub-module, load_fmt: combinational byte-select/extension of dm_rdata. It is reusable by a later halfword extension.

Test Plan:
- sw, exe_result=0x100, store_data=0xDEADBEEF: dm_wen=4'b1111 for exactly 1 cycle, MEM_over in the same cycle, memory word 0x100 = 0xDEADBEEF.
- sb, exe_result=0x103, store_data=0x12: dm_wen=4'b1000, dm_wdata=0x12121212, other bytes unchanged.
- lb, exe_result=0x101, word=0x0000_80FF:
  - LOAD_LATENCY=1: MEM_over 2 cycles after MEM_valid rises, mem_result=0xFFFFFF80.
  - lbu: mem_result=0x00000080.
- lw with LOAD_LATENCY=3: MEM_over 4 cycles after MEM_valid rises. Drop MEM_valid at cycle 2: state returns to IDLE, load_result_r unchanged.
- addu with exe_result=0x5, wen=1, wdest=3, pc=0xBFC00010:
  - MEM_over in the same cycle, dm_wen=0;
  - MEM_WB_bus={1,5'd3,0x5,0xBFC00010}.
- MEM_ALIGN_CHK_EN, sw at 0x102: mem_addr_err=1, dm_wen=0, bus wen=0. Reset asserted in WAIT: state is IDLE next cycle and MEM_over=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, the EXE->MEM
// bus layout, mem_control bit positions and the stage state encoding.
package mem_stage_pkg;

  localparam int EXE_MEM_W = 106;
  localparam int MEM_WB_W  = 70;

  localparam int MC_LOAD  = 3;
  localparam int MC_STORE = 2;
  localparam int MC_WORD  = 1;
  localparam int MC_SIGN  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]  mem_control;
    logic [31:0] store_data;
    logic [31:0] exe_result;
    logic        wen;
    logic [4:0]  wdest;
    logic [31:0] pc;
  } exe_mem_bus_t;

endpackage

// File: rtl/mem_stage_load_fmt.sv
// Load formatter: selects the addressed byte of a read word and sign- or
// zero-extends it; whole words pass straight through.
module load_fmt (
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_sel,
  input  logic        ls_word,
  input  logic        lb_sign,
  output logic [31:0] result
);

  logic [7:0] byte_val;

  always_comb begin
    byte_val = rdata[{byte_sel, 3'b000} +: 8];
    if (ls_word) begin
      result = rdata;
    end else begin
      result = {{24{lb_sign & byte_val[7]}}, byte_val};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives the data-memory port and builds the MEM->WB bus.
// Optional misaligned-access check is enabled with `define MEM_ALIGN_CHK_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MEM_valid,
  input  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r,
  input  logic [31:0]          dm_rdata,
  output logic [31:0]          dm_addr,
  output logic [3:0]           dm_wen,
  output logic [31:0]          dm_wdata,
  output logic                 MEM_over,
  output logic [MEM_WB_W-1:0]  MEM_WB_bus,
  output logic [31:0]          MEM_pc,
  output logic                 mem_addr_err
);

  exe_mem_bus_t bus;
  state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]  load_result_q, load_result_d;
  logic [31:0]  load_fmt_data;
  logic [31:0]  mem_result;
  logic         inst_load, inst_store, ls_word, lb_sign;
  logic         misaligned;

  assign bus        = exe_mem_bus_t'(EXE_MEM_bus_r);
  assign inst_load  = bus.mem_control[MC_LOAD];
  assign inst_store = bus.mem_control[MC_STORE];
  assign ls_word    = bus.mem_control[MC_WORD];
  assign lb_sign    = bus.mem_control[MC_SIGN];

`ifdef MEM_ALIGN_CHK_EN
  assign misaligned = ls_word && (bus.exe_result[1:0] != 2'b00) && (inst_load || inst_store);
`else
  assign misaligned = 1'b0;
`endif

  load_fmt u_load_fmt (
    .rdata    (dm_rdata),
    .byte_sel (bus.exe_result[1:0]),
    .ls_word  (ls_word),
    .lb_sign  (lb_sign),
    .result   (load_fmt_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      load_result_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      load_result_q <= load_result_d;
    end
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    load_result_d = load_result_q;
    unique case (state_q)
      IDLE: begin
        if (MEM_valid) begin
          if (inst_load && !misaligned) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LOAD_LATENCY - 1);
          end else begin
            state_d = DONE;
          end
        end
      end
      WAIT: begin
        if (!MEM_valid) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          load_result_d = load_fmt_data;
          state_d       = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (!MEM_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    MEM_over     = ((state_q == IDLE) && MEM_valid && !inst_load) || (state_q == DONE);
    mem_addr_err = (state_q == IDLE) && MEM_valid && misaligned;
    dm_addr      = {bus.exe_result[31:2], 2'b00};
    dm_wdata     = ls_word ? bus.store_data : {4{bus.store_data[7:0]}};
    dm_wen       = 4'b0000;
    // Writes only fire in the first valid cycle, so sitting in DONE never repeats them.
    if ((state_q == IDLE) && MEM_valid && inst_store && !inst_load && !misaligned) begin
      dm_wen = ls_word ? 4'b1111 : (4'b0001 << bus.exe_result[1:0]);
    end
    mem_result = inst_load ? load_result_q : bus.exe_result;
    MEM_WB_bus = {bus.wen & ~misaligned, bus.wdest, mem_result, bus.pc};
    MEM_pc     = bus.pc;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: two instances (load latency 1 and 3) share
// one stimulus stream and a behavioural data memory with per-instance read delay.
module tb_mem_stage;

  logic         clk;
  logic         reset;
  logic         mem_valid;
  logic [105:0] bus_in;
  logic [31:0]  rdata1, rdata3;
  logic [31:0]  addr1, addr3, wdata1, wdata3, pc1, pc3;
  logic [3:0]   wen1, wen3;
  logic         over1, over3, err1, err3;
  logic [69:0]  wb1, wb3;

  int n_checks = 0;
  int n_err    = 0;

  mem_stage #(.LOAD_LATENCY(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .MEM_valid(mem_valid), .EXE_MEM_bus_r(bus_in),
    .dm_rdata(rdata1), .dm_addr(addr1), .dm_wen(wen1), .dm_wdata(wdata1),
    .MEM_over(over1), .MEM_WB_bus(wb1), .MEM_pc(pc1), .mem_addr_err(err1)
  );

  mem_stage #(.LOAD_LATENCY(3), .CNT_W(2)) u_dut3 (
    .clk(clk), .reset(reset), .MEM_valid(mem_valid), .EXE_MEM_bus_r(bus_in),
    .dm_rdata(rdata3), .dm_addr(addr3), .dm_wen(wen3), .dm_wdata(wdata3),
    .MEM_over(over3), .MEM_WB_bus(wb3), .MEM_pc(pc3), .mem_addr_err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory: writes come from the latency-1 instance only
  // (both issue identical stores); reads are delayed 1 and 3 cycles.
  logic [31:0] mem [256];
  logic [31:0] p1, p3a, p3b, p3c;
  assign rdata1 = p1;
  assign rdata3 = p3c;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i) * 32'h0103_0507;
      p1 <= '0; p3a <= '0; p3b <= '0; p3c <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (wen1[b]) mem[addr1[9:2]][8*b +: 8] <= wdata1[8*b +: 8];
      p1  <= mem[addr1[9:2]];
      p3a <= mem[addr3[9:2]];
      p3b <= p3a;
      p3c <= p3b;
    end
  end

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                           input logic word, input logic sgn);
    logic [31:0] b;
    b = (w >> (8 * a)) & 32'hFF;
    if (word) return w;
    if (sgn && b >= 32'd128) return b | 32'hFFFF_FF00;
    return b;
  endfunction

  function automatic logic exp_over(input int lat, input int k, input logic ld, input logic mis);
    if (!ld) return 1'b1;
    if (mis) return k >= 1;
    return k >= lat + 1;
  endfunction

  // One stage transaction: valid held for 'hold' cycles, then dropped.
  task automatic txn(input logic ld, input logic st, input logic word, input logic sgn,
                     input logic [31:0] sd, input logic [31:0] ea, input logic wen,
                     input logic [4:0] wd, input logic [31:0] pc, input int hold);
    logic        mis;
    logic [7:0]  idx;
    logic [31:0] old, exp_res, exp_word, exp_wdata, lane_mask;
    logic [3:0]  exp_wen;
    idx = ea[9:2];
    @(posedge clk); #1;
    old = mem[idx];
`ifdef MEM_ALIGN_CHK_EN
    mis = word && (ea[1:0] != 2'b00) && (ld || st);
`else
    mis = 1'b0;
`endif
    exp_res   = ld ? ref_load(old, ea[1:0], word, sgn) : ea;
    exp_wen   = (st && !ld && !mis) ? (word ? 4'hF : 4'(1 << ea[1:0])) : 4'h0;
    exp_wdata = word ? sd : {4{sd[7:0]}};
    lane_mask = 32'hFF << (8 * ea[1:0]);
    if (exp_wen == 4'h0)  exp_word = old;
    else if (word)        exp_word = sd;
    else                  exp_word = (old & ~lane_mask) | ((sd & 32'hFF) << (8 * ea[1:0]));

    bus_in    = {ld, st, word, sgn, sd, ea, wen, wd, pc};
    mem_valid = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("over_lat1", over1, exp_over(1, k, ld, mis));
      check("over_lat3", over3, exp_over(3, k, ld, mis));
      check("dm_wen_lat1", wen1, (k == 0) ? exp_wen : 4'h0);
      check("dm_wen_lat3", wen3, (k == 0) ? exp_wen : 4'h0);
      check("addr_err", err1, (k == 0) && mis);
      if (k == 0) begin
        check("dm_addr", addr3, {ea[31:2], 2'b00});
        if (exp_wen != 4'h0) check("dm_wdata", wdata1, exp_wdata);
      end
      if (k == hold - 1 && hold >= 5 && !(ld && mis)) begin
        check("wb_bus_lat1", wb1, {wen & ~mis, wd, exp_res, pc});
        check("wb_bus_lat3", wb3, {wen & ~mis, wd, exp_res, pc});
        check("mem_pc", pc1, pc);
      end
      @(posedge clk); #1;
    end
    mem_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("over_idle_lat1", over1, 1'b0);
    check("over_idle_lat3", over3, 1'b0);
    if (hold >= 5) check("mem_word", mem[idx], exp_word);
  endtask

  initial begin
    int unsigned op;
    logic [31:0] ea;
    reset     = 1'b1;
    mem_valid = 1'b0;
    bus_in    = {4'b1010, 32'h0, 32'h100, 1'b1, 5'd1, 32'h0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_over", {over1, over3}, 2'b00);
    check("rst_wen", {wen1, wen3}, 8'h00);
    check("rst_err", {err1, err3}, 2'b00);
    check("rst_load_result", {wb1[63:32], wb3[63:32]}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ld st word sgn  store_data    exe_result  wen wdest pc
    txn(1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h100, 1'b0, 5'd0, 32'hBFC0_0000, 5);
    txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0012, 32'h103, 1'b0, 5'd0, 32'hBFC0_0004, 5);
    txn(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_80FF, 32'h100, 1'b0, 5'd0, 32'hBFC0_0008, 5);
    txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         32'h101, 1'b1, 5'd4, 32'hBFC0_000C, 5);
    check("lb_value", wb1[63:32], 32'hFFFF_FF80);
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h101, 1'b1, 5'd5, 32'hBFC0_0010, 5);
    check("lbu_value", wb3[63:32], 32'h0000_0080);

    // lw aborted after two valid cycles: latency-3 instance must not capture
    txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'h100, 1'b1, 5'd6, 32'hBFC0_0014, 2);
    check("abort_keeps_result", wb3[63:32], 32'h0000_0080);
    check("lat1_captured", wb1[63:32], 32'h0000_80FF);

    txn(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h5,   1'b1, 5'd3, 32'hBFC0_0010, 5);
    check("addu_bus", wb1, {1'b1, 5'd3, 32'h5, 32'hBFC0_0010});
    txn(1'b1, 1'b1, 1'b1, 1'b0, 32'h5555_AAAA, 32'h104, 1'b1, 5'd7, 32'hBFC0_0018, 5);
    txn(1'b0, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D, 32'h102, 1'b1, 5'd8, 32'hBFC0_001C, 5);

    // reset while both instances wait on a load
    @(posedge clk); #1;
    bus_in    = {4'b1010, 32'h0, 32'h100, 1'b1, 5'd9, 32'hBFC0_0020};
    mem_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_wait_over", {over1, over3}, 2'b00);
    check("rst_wait_result", {wb1[63:32], wb3[63:32]}, 64'h0);
    check("rst_wait_wen", {wen1, wen3}, 8'h00);
    @(posedge clk); #1;
    reset     = 1'b0;
    mem_valid = 1'b0;
    repeat (2) @(posedge clk);

    for (int n = 0; n < 24; n++) begin
      op = $urandom_range(0, 5);
      ea = $urandom();
      case (op)
        0: txn(1'b0, 1'b1, 1'b1, 1'b0, $urandom(), {ea[31:2], 2'b00}, 1'($urandom()), 5'($urandom()), $urandom(), 5);
        1: txn(1'b0, 1'b1, 1'b0, 1'b0, $urandom(), ea,                1'($urandom()), 5'($urandom()), $urandom(), 5);
        2: txn(1'b1, 1'b0, 1'b1, 1'b0, $urandom(), {ea[31:2], 2'b00}, 1'($urandom()), 5'($urandom()), $urandom(), 5);
        3: txn(1'b1, 1'b0, 1'b0, 1'b1, $urandom(), ea,                1'($urandom()), 5'($urandom()), $urandom(), 5);
        4: txn(1'b1, 1'b0, 1'b0, 1'b0, $urandom(), ea,                1'($urandom()), 5'($urandom()), $urandom(), 5);
        default: txn(1'b0, 1'b0, 1'b0, 1'b0, $urandom(), ea,          1'($urandom()), 5'($urandom()), $urandom(), 5);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
